// File: rtl/led_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : led_bank_scheduler
// Description : Round-robin time-sharing of the LED output bank between
//               NUM_REQ pattern requesters, with a per-grant hold window in
//               prescaled ticks and a heartbeat count when the bank is idle.
//               Optional macro LED_BANK_PWM_EN adds a brightness input that
//               gates the registered LED drive with a 4-bit PWM.
// Revision    : 1.0 - initial release
// ============================================================================
module led_bank_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int LED_W      = 8,
  parameter int PRESCALE_W = 18,
  parameter int HOLD_TICKS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] req_pat,
`ifdef LED_BANK_PWM_EN
  input  logic [3:0]               brightness,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         leds,
  output logic                     tick,
  output logic                     busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_HANDOFF = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   prescaler_q, prescaler_d;
  logic                    tick_q, tick_d;
  logic [LED_W-1:0]        heartbeat_q, heartbeat_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [LED_W-1:0]        leds_q, leds_d;

  logic [IDX_W:0]          win_sum;
  logic [IDX_W-1:0]        win_idx;
  logic [NUM_REQ-1:0]      win_onehot;
  logic [LED_W-1:0]        owner_pat;
  logic [IDX_W-1:0]        owner_next;
  logic                    owner_req;
  logic                    other_req;

  // Free-running prescaler; tick is high in the cycle the prescaler reads 0 after a wrap.
  always_comb begin
    prescaler_d = prescaler_q + PRESCALE_W'(1);
    tick_d      = &prescaler_q;
    heartbeat_d = tick_q ? heartbeat_q + LED_W'(1) : heartbeat_q;
  end

  // Round-robin winner: scan downward so the lowest offset from rr_ptr is kept last.
  always_comb begin
    win_sum = '0;
    win_idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      win_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(j);
      if (win_sum >= (IDX_W + 1)'(NUM_REQ)) begin
        win_sum = win_sum - (IDX_W + 1)'(NUM_REQ);
      end
      if (req[win_sum[IDX_W-1:0]]) begin
        win_idx = win_sum[IDX_W-1:0];
      end
    end
    win_onehot = NUM_REQ'(1) << win_idx;
  end

  // Owner's pattern slice and request status relative to the current owner.
  always_comb begin
    owner_pat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_pat = req_pat[i*LED_W +: LED_W];
      end
    end
    owner_req  = |(req & grant_q);
    other_req  = |(req & ~grant_q);
    owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
  end

  // Ownership FSM: next state, grant, hold window and LED source selection.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    grant_d  = grant_q;
    leds_d   = leds_q;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        leds_d  = heartbeat_q;
        if (|req) begin
          state_d = ST_OWN;
          grant_d = win_onehot;
          owner_d = win_idx;
          hold_d  = HOLD_W'(HOLD_TICKS);
        end
      end
      ST_OWN: begin
        leds_d = owner_pat;
        if (tick_q && (hold_q != '0)) begin
          hold_d = hold_q - HOLD_W'(1);
        end
        // A dropped request and an expired window with waiters both yield the bank.
        if (!owner_req || ((hold_q == '0) && other_req)) begin
          state_d  = ST_HANDOFF;
          grant_d  = '0;
          leds_d   = '0;
          rr_ptr_d = owner_next;
        end else if (hold_q == '0) begin
          hold_d = HOLD_W'(HOLD_TICKS);
        end
      end
      ST_HANDOFF: begin
        grant_d = '0;
        leds_d  = '0;
        if (|req) begin
          state_d = ST_OWN;
          grant_d = win_onehot;
          owner_d = win_idx;
          hold_d  = HOLD_W'(HOLD_TICKS);
        end else begin
          // Returning to idle: resume the heartbeat right after the blank cycle.
          state_d = ST_IDLE;
          leds_d  = heartbeat_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        leds_d  = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prescaler_q <= '0;
      tick_q      <= 1'b0;
      heartbeat_q <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      hold_q      <= '0;
      grant_q     <= '0;
      leds_q      <= '0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      tick_q      <= tick_d;
      heartbeat_q <= heartbeat_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      leds_q      <= leds_d;
    end
  end

  assign grant = grant_q;
  assign tick  = tick_q;
  assign busy  = (state_q != ST_IDLE);

`ifdef LED_BANK_PWM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;

  // 4-bit PWM phase counter that advances every cycle.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
  end

  // PWM phase register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Brightness gating sits after the handoff blanking, so a blank stays blank.
  assign leds = leds_q & {LED_W{(pwm_cnt_q < brightness)}};
`else
  assign leds = leds_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_bank_scheduler
// Description : Directed self-checking bench for led_bank_scheduler
//               (NUM_REQ=4, LED_W=8, PRESCALE_W=2, HOLD_TICKS=2).
//               Exercises LED_BANK_PWM_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_bank_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_pat;
  logic [3:0]  grant;
  logic [7:0]  leds;
  logic        tick;
  logic        busy;
  logic [3:0]  brightness;
  logic [3:0]  pwm_m;

  int tests;
  int fails;
  int on_cnt;

  logic [7:0] exp_idle_leds [0:9];
  logic       exp_idle_tick [0:9];
  logic [3:0] exp_g;

  led_bank_scheduler #(
    .NUM_REQ   (4),
    .LED_W     (8),
    .PRESCALE_W(2),
    .HOLD_TICKS(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_pat   (req_pat),
`ifdef LED_BANK_PWM_EN
    .brightness(brightness),
`endif
    .grant     (grant),
    .leds      (leds),
    .tick      (tick),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    pwm_m = rst_n ? pwm_m + 4'd1 : 4'd0;
    #1;
    tests++;
    assert ($onehot0(grant)) else begin
      fails++;
      $error("FAIL grant_onehot0 observed=%b expected=one-hot-or-zero", grant);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // LED comparison; with PWM enabled the expected drive is gated by the phase model.
  task automatic chk_leds(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    e = exp;
`ifdef LED_BANK_PWM_EN
    if (!(pwm_m < brightness)) e = 8'h00;
`endif
    chk(tag, {24'd0, leds}, {24'd0, e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests      = 0;
    fails      = 0;
    on_cnt     = 0;
    pwm_m      = 4'd0;
    rst_n      = 1'b0;
    req        = 4'b0000;
    brightness = 4'd15;
    req_pat    = {8'h44, 8'hA5, 8'h22, 8'h11};
    exp_idle_leds = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
    exp_idle_tick = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // 1. Reset then idle heartbeat
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_leds", {24'd0, leds}, 32'd0);
      chk("rst_grant", {28'd0, grant}, 32'd0);
      chk("rst_tick", {31'd0, tick}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("idle_tick", {31'd0, tick}, {31'd0, exp_idle_tick[n]});
      chk_leds("idle_leds", exp_idle_leds[n]);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // 2. Single owner, then drop
    req = 4'b0100;
    step();
    chk("single_grant", {28'd0, grant}, 32'h4);
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk_leds("single_leds_hb", 8'd2);
    step();
    chk_leds("single_leds_pat", 8'hA5);
    req = 4'b0000;
    step();
    chk("drop_grant", {28'd0, grant}, 32'd0);
    chk_leds("drop_blank", 8'h00);
    chk("drop_busy", {31'd0, busy}, 32'd1);
    step();
    chk("idle_again_grant", {28'd0, grant}, 32'd0);
    chk("idle_again_busy", {31'd0, busy}, 32'd0);
    chk_leds("idle_again_leds", 8'd3);

    // 3. Round-robin pre-emption from a fresh reset
    rst_n = 1'b0;
    step();
    chk("rst2_grant", {28'd0, grant}, 32'd0);
    rst_n = 1'b1;
    req   = 4'b1011;
    for (int n = 1; n <= 28; n++) begin
      step();
      if (n <= 9)       exp_g = 4'b0001;
      else if (n == 10) exp_g = 4'b0000;
      else if (n <= 17) exp_g = 4'b0010;
      else if (n == 18) exp_g = 4'b0000;
      else if (n <= 25) exp_g = 4'b1000;
      else if (n == 26) exp_g = 4'b0000;
      else              exp_g = 4'b0001;
      chk("rr_grant", {28'd0, grant}, {28'd0, exp_g});
      chk("rr_busy", {31'd0, busy}, 32'd1);
      if (n == 2)  chk_leds("rr_leds_o0", 8'h11);
      if (n == 10) chk_leds("rr_leds_blank", 8'h00);
      if (n == 11) chk_leds("rr_leds_first", 8'h00);
      if (n == 12) chk_leds("rr_leds_o1", 8'h22);
      if (n == 20) chk_leds("rr_leds_o3", 8'h44);
      if (n == 28) chk_leds("rr_leds_o0b", 8'h11);
    end

    // 4. Sole requester keeps the bank across hold expiries
    req = 4'b0001;
    for (int n = 0; n < 40; n++) begin
      step();
      chk("sole_grant", {28'd0, grant}, 32'h1);
      chk_leds("sole_leds", 8'h11);
    end

    // 5. Reset while requester 1 owns the bank
    req = 4'b0010;
    step();
    chk("mid_handoff", {28'd0, grant}, 32'd0);
    step();
    chk("mid_owner1", {28'd0, grant}, 32'h2);
    step();
    chk_leds("mid_leds1", 8'h22);
    rst_n = 1'b0;
    req   = 4'b0011;
    step();
    chk("mid_rst_grant", {28'd0, grant}, 32'd0);
    chk("mid_rst_leds", {24'd0, leds}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_grant", {28'd0, grant}, 32'h1);
    step();
    chk_leds("post_rst_leds", 8'h11);

`ifdef LED_BANK_PWM_EN
    // 6. PWM duty with a full-on pattern
    req_pat[7:0] = 8'hFF;
    brightness   = 4'd4;
    step();
    for (int n = 0; n < 16; n++) begin
      step();
      chk_leds("pwm_b4", 8'hFF);
      if (leds == 8'hFF) on_cnt++;
    end
    chk("pwm_duty", on_cnt, 32'd4);
    brightness = 4'd0;
    for (int n = 0; n < 16; n++) begin
      step();
      chk("pwm_b0", {24'd0, leds}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
